// File: rtl/gray_pipe_accum.sv
// Three-stage pipelined Gray-code adder/accumulator with valid/ready handshake.
// Define GRAY_PIPE_ACC_SAT_EN to saturate the accumulator instead of wrapping it.
`default_nettype none

module gray_pipe_accum #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         clr_acc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_result,
    output logic [N-1:0] acc_gray
);

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [N:0] bin2gray(input logic [N:0] b);
        logic [N:0] g;
        g[N] = b[N];
        for (int i = N - 1; i >= 0; i--) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    logic         r_s1_valid;
    logic         r_s1_mode;
    logic [N-1:0] r_s1_a;
    logic [N-1:0] r_s1_b;
    logic         r_s2_valid;
    logic [N:0]   r_s2_sum;
    logic         r_out_valid;
    logic [N:0]   r_out_result;
    logic [N-1:0] r_acc;

    logic         w_adv;
    logic [N:0]   w_s2_sum;
    logic [N-1:0] w_acc_next;
    logic         w_acc_commit;
    logic [N:0]   w_acc_gray_ext;

    // One global advance: every stage shifts or holds together, bubbles included.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // NOTE: a continuous assign or an always_comb with a value on every path
    // cannot infer a latch; a missing else branch in always_comb would.
    assign w_s2_sum = r_s1_mode ? ({1'b0, r_acc}  + {1'b0, r_s1_a})
                                : ({1'b0, r_s1_a} + {1'b0, r_s1_b});

`ifdef GRAY_PIPE_ACC_SAT_EN
    assign w_acc_next = w_s2_sum[N] ? {N{1'b1}} : w_s2_sum[N-1:0];
`else
    assign w_acc_next = w_s2_sum[N-1:0];
`endif

    assign w_acc_commit   = w_adv && r_s1_valid && r_s1_mode;
    assign w_acc_gray_ext = bin2gray({1'b0, r_acc});
    assign acc_gray       = w_acc_gray_ext[N-1:0];

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous-cycle value of the stage before it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_mode    <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_sum     <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
        end else if (w_adv) begin
            r_s1_valid   <= in_valid;
            r_s1_mode    <= in_mode;
            r_s1_a       <= gray2bin(in_a);
            r_s1_b       <= gray2bin(in_b);
            r_s2_valid   <= r_s1_valid;
            r_s2_sum     <= w_s2_sum;
            r_out_valid  <= r_s2_valid;
            r_out_result <= bin2gray(r_s2_sum);
        end
    end

    // Clear wins over a same-edge ACC commit; that beat's sum already used the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (clr_acc) begin
            r_acc <= '0;
        end else if (w_acc_commit) begin
            r_acc <= w_acc_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gray_pipe_accum.sv
// Scoreboard bench for gray_pipe_accum (N=4); honours GRAY_PIPE_ACC_SAT_EN in its model.
`timescale 1ns/1ps

module tb_gray_pipe_accum;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         clr_acc;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out_result;
    logic [N-1:0] acc_gray;

    gray_pipe_accum #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .clr_acc   (clr_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .acc_gray  (acc_gray)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [N:0]   exp_q[$];
    logic [N-1:0] acc_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_g2b(input logic [N-1:0] g);
        logic [N-1:0] b = '0;
        logic         x = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            x    = x ^ g[i];
            b[i] = x;
        end
        return b;
    endfunction

    function automatic logic [N:0] m_b2g(input logic [N:0] b);
        return b ^ (b >> 1);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic mode, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        int         t = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            if (mode) begin
                s = {1'b0, acc_m} + {1'b0, m_g2b(a)};
`ifdef GRAY_PIPE_ACC_SAT_EN
                acc_m = s[N] ? {N{1'b1}} : s[N-1:0];
`else
                acc_m = s[N-1:0];
`endif
            end else begin
                s = {1'b0, m_g2b(a)} + {1'b0, m_g2b(b)};
            end
            exp_q.push_back(m_b2g(s));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        idle();
        while ((exp_q.size() != 0 || out_valid) && t < 60) begin
            t++;
            @(negedge clk);
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [N:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {27'd0, out_result}, {27'd0, e});
            end
        end
    end

    initial begin
        logic [N:0] held;
        int         seen;
        int         vcnt;

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_a = '0; in_b = '0;
        clr_acc = 1'b0; out_ready = 1'b1; acc_m = '0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {27'd0, out_result}, 32'd0);
        check("rst_acc_gray", {28'd0, acc_gray}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD 4+5 with latency probe
        send(1'b0, 4'b0110, 4'b0111);
        idle();
        check("lat_edge_k", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge_k1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge_k2", {31'd0, out_valid}, 32'd1);
        drain();

        // ADD 15+15 and back-to-back ACC 15, 1
        send(1'b0, 4'b1000, 4'b1000);
        send(1'b1, 4'b1000, 4'b0000);
        send(1'b1, 4'b0001, 4'b1111);
        drain();
        check("acc_after_15_1", {28'd0, acc_gray}, {28'd0, m_b2g({1'b0, acc_m})});

        // clear while idle, then clear on the commit edge of an ACC beat
        clr_acc = 1'b1;
        @(posedge clk); #1;
        clr_acc = 1'b0;
        acc_m = '0;
        check("acc_idle_clr", {28'd0, acc_gray}, 32'd0);
        send(1'b1, 4'b0010, 4'b0000);
        send(1'b1, 4'b0011, 4'b0000);
        idle();
        clr_acc = 1'b1;
        @(posedge clk); #1;
        clr_acc = 1'b0;
        acc_m = '0;
        check("acc_clr_commit", {28'd0, acc_gray}, 32'd0);
        drain();
        check("acc_clr_hold", {28'd0, acc_gray}, 32'd0);

        // backpressure: 4 ADD beats, 5-cycle stall after first result
        fork
            begin
                send(1'b0, 4'b0001, 4'b0010);
                send(1'b0, 4'b0011, 4'b0110);
                send(1'b0, 4'b0111, 4'b0101);
                send(1'b0, 4'b1100, 4'b1010);
                idle();
            end
            begin
                seen = 0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1;
                end
                check("stall_first_seen", seen, 32'd1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                held = out_result;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check("stall_held", {27'd0, out_result}, {27'd0, held});
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // random mix of modes with random backpressure
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    send(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
                end
                idle();
            end
            begin
                for (int c = 0; c < 50; c++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        check("acc_after_random", {28'd0, acc_gray}, {28'd0, m_b2g({1'b0, acc_m})});

        // reset with three ACC beats in flight
        send(1'b1, 4'b0111, 4'b0000);
        send(1'b1, 4'b0101, 4'b0000);
        send(1'b1, 4'b0100, 4'b0000);
        idle();
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_result", {27'd0, out_result}, 32'd0);
        check("midrst_acc_gray", {28'd0, acc_gray}, 32'd0);
        exp_q.delete();
        acc_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check("no_stale_beats", vcnt, 32'd0);
        @(posedge clk); #1;

        // pipeline usable again after reset
        send(1'b1, 4'b0011, 4'b0000);
        drain();
        check("acc_post_rst", {28'd0, acc_gray}, {28'd0, m_b2g({1'b0, acc_m})});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
